// File: rtl/mem_bus_mmio_if.sv
// Memory-stage bus bundle: CPU-side load/store request, DataMemory handshake,
// load result and the peripheral outputs driven by the MMIO block.
interface mem_bus_mmio_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] ram_rdata;
    logic        ram_read;
    logic        ram_write;
    logic [31:0] Read_data;
    logic [7:0]  leds;
    logic [11:0] digi;
    logic        irq;

    modport master (
        output MemRead, MemWrite, Address, Write_data, ram_rdata,
        input  ram_read, ram_write, Read_data, leds, digi, irq
    );

    modport slave (
        input  MemRead, MemWrite, Address, Write_data, ram_rdata,
        output ram_read, ram_write, Read_data, leds, digi, irq
    );
endinterface

// File: rtl/mem_bus_mmio.sv
// Memory-stage bus: routes RAM accesses to DataMemory and hosts the timer, LED,
// 7-segment and systick registers; returns the muxed load word to MEM/WB.
module mem_bus_mmio #(
    parameter int unsigned RAM_SIZE_BIT = 8,
    parameter logic [31:0] PERIPH_BASE  = 32'h4000_0000
) (
    input  logic          clk,
    input  logic          reset,
    mem_bus_mmio_if.slave bus
);
    localparam logic [32:0] RAM_BYTES    = 33'd4 << RAM_SIZE_BIT;
    localparam logic [29:0] PERIPH_WBASE = PERIPH_BASE[31:2];

    typedef enum logic [2:0] {
        REG_TH   = 3'd0,
        REG_TL   = 3'd1,
        REG_TCON = 3'd2,
        REG_LED  = 3'd3,
        REG_DIGI = 3'd4,
        REG_TICK = 3'd5
    } reg_sel_e;

    logic        ram_hit;
    logic        periph_hit;
    logic [29:0] word_off;
    reg_sel_e    reg_sel;

    logic [31:0] th_q,   th_d;
    logic [31:0] tl_q,   tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q,  led_d;
    logic [11:0] digi_q, digi_d;
    logic [31:0] tick_q, tick_d;

    logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
    logic        overflow;
    logic [31:0] rdata;

    // Word-granular decode; RAM takes precedence should the windows ever overlap.
    assign ram_hit    = {1'b0, bus.Address} < RAM_BYTES;
    assign word_off   = bus.Address[31:2] - PERIPH_WBASE;
    assign periph_hit = !ram_hit && (word_off < 30'd6);
    assign reg_sel    = reg_sel_e'(word_off[2:0]);

    assign wr_th   = bus.MemWrite && periph_hit && (reg_sel == REG_TH);
    assign wr_tl   = bus.MemWrite && periph_hit && (reg_sel == REG_TL);
    assign wr_tcon = bus.MemWrite && periph_hit && (reg_sel == REG_TCON);
    assign wr_led  = bus.MemWrite && periph_hit && (reg_sel == REG_LED);
    assign wr_digi = bus.MemWrite && periph_hit && (reg_sel == REG_DIGI);

    assign bus.ram_read  = bus.MemRead  & ram_hit;
    assign bus.ram_write = bus.MemWrite & ram_hit;

    always_comb begin
        rdata = 32'd0;
        if (bus.MemRead) begin
            if (ram_hit) begin
                rdata = bus.ram_rdata;
            end else if (periph_hit) begin
                case (reg_sel)
                    REG_TH:   rdata = th_q;
                    REG_TL:   rdata = tl_q;
                    REG_TCON: rdata = {29'd0, tcon_q};
                    REG_LED:  rdata = {24'd0, led_q};
                    REG_DIGI: rdata = {20'd0, digi_q};
                    REG_TICK: rdata = tick_q;
                    default:  rdata = 32'd0;
                endcase
            end
        end
    end

    assign bus.Read_data = rdata;

    always_comb begin
        th_d     = th_q;
        tl_d     = tl_q;
        tcon_d   = tcon_q;
        led_d    = led_q;
        digi_d   = digi_q;
        tick_d   = tick_q + 32'd1;
        overflow = 1'b0;

        if (wr_th)   th_d   = bus.Write_data;
        if (wr_led)  led_d  = bus.Write_data[7:0];
        if (wr_digi) digi_d = bus.Write_data[11:0];

        // A CPU store to TL suppresses both the increment and the reload.
        if (wr_tl) begin
            tl_d = bus.Write_data;
        end else if (tcon_q[0]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d     = th_q;
                overflow = tcon_q[1];
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end

        if (wr_tcon) begin
            tcon_d[1:0] = bus.Write_data[1:0];
            tcon_d[2]   = tcon_q[2] & bus.Write_data[2];
        end
        // Overflow status is set after any clear so a simultaneous event is not lost.
        if (overflow) tcon_d[2] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q   <= 32'd0;
            tl_q   <= 32'd0;
            tcon_q <= 3'd0;
            led_q  <= 8'd0;
            digi_q <= 12'd0;
            tick_q <= 32'd0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            led_q  <= led_d;
            digi_q <= digi_d;
            tick_q <= tick_d;
        end
    end

    assign bus.leds = led_q;
    assign bus.digi = digi_q;
    assign bus.irq  = tcon_q[1] & tcon_q[2];
endmodule

// File: tb/tb_mem_bus_mmio.sv
// Bench for mem_bus_mmio: directed vector table, hand-written timer sequences and
// randomized traffic checked against an address-map level reference model.
module tb_mem_bus_mmio;
    localparam logic [31:0] BASE      = 32'h4000_0000;
    localparam logic [31:0] RAM_BYTES = 32'd1024;

    logic clk;
    logic reset;

    mem_bus_mmio_if bus ();

    mem_bus_mmio #(
        .RAM_SIZE_BIT (8),
        .PERIPH_BASE  (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: the peripheral registers as the programmer sees them.
    logic [31:0] m_th, m_tl, m_tick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [11:0] m_digi;

    logic [31:0] s_rd;
    logic        s_rr, s_rw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pidx(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w < RAM_BYTES) return -1;
        if (w >= BASE && w < BASE + 32'd24) return int'((w - BASE) / 4);
        return -1;
    endfunction

    function automatic logic [31:0] model_rd(input logic mr, input logic [31:0] a,
                                             input logic [31:0] rram);
        if (!mr) return 32'd0;
        if (a < RAM_BYTES) return rram;
        case (pidx(a))
            0: return m_th;
            1: return m_tl;
            2: return {29'd0, m_tcon};
            3: return {24'd0, m_led};
            4: return {20'd0, m_digi};
            5: return m_tick;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic mw, input logic [31:0] a,
                              input logic [31:0] wd);
        logic [31:0] n_th, n_tl;
        logic [2:0]  n_tcon;
        logic        ovf;
        int          k;
        if (rst) begin
            m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_tick = 0;
            return;
        end
        k = mw ? pidx(a) : -1;
        n_th = m_th; n_tl = m_tl; n_tcon = m_tcon; ovf = 1'b0;
        if (k == 0) n_th = wd;
        if (k == 1) n_tl = wd;
        else if (m_tcon[0]) begin
            if (m_tl == 32'hFFFF_FFFF) begin
                n_tl = m_th;
                ovf  = m_tcon[1];
            end else n_tl = m_tl + 1;
        end
        if (k == 2) n_tcon = {m_tcon[2] & wd[2], wd[1:0]};
        if (ovf) n_tcon[2] = 1'b1;
        if (k == 3) m_led = wd[7:0];
        if (k == 4) m_digi = wd[11:0];
        m_th = n_th; m_tl = n_tl; m_tcon = n_tcon;
        m_tick = m_tick + 1;
    endtask

    task automatic step(input logic rst, input logic mr, input logic mw,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rram);
        @(negedge clk);
        reset          = rst;
        bus.MemRead    = mr;
        bus.MemWrite   = mw;
        bus.Address    = a;
        bus.Write_data = wd;
        bus.ram_rdata  = rram;
        #1;
        s_rd = bus.Read_data;
        s_rr = bus.ram_read;
        s_rw = bus.ram_write;
        chk("model_read_data", s_rd, model_rd(mr, a, rram));
        chk("model_ram_read",  {31'd0, s_rr}, {31'd0, mr && (a < RAM_BYTES)});
        chk("model_ram_write", {31'd0, s_rw}, {31'd0, mw && (a < RAM_BYTES)});
        model_edge(rst, mw, a, wd);
        @(posedge clk);
        #1;
        chk("model_leds", {24'd0, bus.leds}, {24'd0, m_led});
        chk("model_digi", {20'd0, bus.digi}, {20'd0, m_digi});
        chk("model_irq",  {31'd0, bus.irq},  {31'd0, m_tcon[1] & m_tcon[2]});
    endtask

    typedef struct {
        logic        rst, mr, mw;
        logic [31:0] addr, wd, rram;
        logic [31:0] e_rd;
        logic        e_rr, e_rw;
        logic [7:0]  e_led;
        logic [11:0] e_digi;
    } vec_t;

    function automatic vec_t mkv(input logic rst, input logic mr, input logic mw,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rram, input logic [31:0] e_rd,
                                 input logic e_rr, input logic e_rw,
                                 input logic [7:0] e_led, input logic [11:0] e_digi);
        vec_t v;
        v.rst = rst; v.mr = mr; v.mw = mw; v.addr = addr; v.wd = wd; v.rram = rram;
        v.e_rd = e_rd; v.e_rr = e_rr; v.e_rw = e_rw; v.e_led = e_led; v.e_digi = e_digi;
        return v;
    endfunction

    vec_t vt[$];

    initial begin
        logic [31:0] a, wd;
        int          sel;

        m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_tick = 0;
        reset = 1'b1;
        bus.MemRead = 0; bus.MemWrite = 0; bus.Address = 0;
        bus.Write_data = 0; bus.ram_rdata = 0;

        //            rst mr mw addr           wd             rram           e_rd           rr rw led    digi
        vt.push_back(mkv(1, 0, 1, 32'h4000_000C, 32'h0000_00FF, 32'h0,         32'h0,         0, 0, 8'h00, 12'h000));
        vt.push_back(mkv(0, 1, 0, 32'h0000_0008, 32'h0,         32'h0000_3AF2, 32'h0000_3AF2, 1, 0, 8'h00, 12'h000));
        vt.push_back(mkv(0, 0, 1, 32'h0000_0004, 32'h0000_1234, 32'h0,         32'h0,         0, 1, 8'h00, 12'h000));
        vt.push_back(mkv(0, 0, 1, 32'h4000_000C, 32'h0000_01A5, 32'h0,         32'h0,         0, 0, 8'hA5, 12'h000));
        vt.push_back(mkv(0, 1, 0, 32'h4000_000C, 32'h0,         32'hDEAD_BEEF, 32'h0000_00A5, 0, 0, 8'hA5, 12'h000));
        vt.push_back(mkv(0, 0, 1, 32'h4000_0010, 32'hFFFF_F3C7, 32'h0,         32'h0,         0, 0, 8'hA5, 12'h3C7));
        vt.push_back(mkv(0, 1, 0, 32'h4000_0010, 32'h0,         32'h0,         32'h0000_03C7, 0, 0, 8'hA5, 12'h3C7));
        vt.push_back(mkv(0, 1, 0, 32'h4000_0020, 32'h0,         32'h0000_5555, 32'h0,         0, 0, 8'hA5, 12'h3C7));
        vt.push_back(mkv(0, 0, 1, 32'h8000_0000, 32'h0,         32'h0,         32'h0,         0, 0, 8'hA5, 12'h3C7));
        vt.push_back(mkv(0, 1, 0, 32'h0000_03FC, 32'h0,         32'h0000_0077, 32'h0000_0077, 1, 0, 8'hA5, 12'h3C7));
        vt.push_back(mkv(0, 1, 0, 32'h0000_0400, 32'h0,         32'h0000_0077, 32'h0,         0, 0, 8'hA5, 12'h3C7));
        vt.push_back(mkv(0, 1, 0, 32'h4000_000E, 32'h0,         32'h0,         32'h0000_00A5, 0, 0, 8'hA5, 12'h3C7));
        vt.push_back(mkv(0, 1, 0, 32'h4000_0014, 32'h0,         32'h0,         32'h0000_000B, 0, 0, 8'hA5, 12'h3C7));
        vt.push_back(mkv(0, 0, 1, 32'h4000_0014, 32'h0,         32'h0,         32'h0,         0, 0, 8'hA5, 12'h3C7));
        vt.push_back(mkv(0, 1, 0, 32'h4000_0014, 32'h0,         32'h0,         32'h0000_000D, 0, 0, 8'hA5, 12'h3C7));
        vt.push_back(mkv(0, 1, 0, 32'h4000_0008, 32'h0,         32'h0,         32'h0,         0, 0, 8'hA5, 12'h3C7));

        foreach (vt[i]) begin
            step(vt[i].rst, vt[i].mr, vt[i].mw, vt[i].addr, vt[i].wd, vt[i].rram);
            chk($sformatf("vec%0d_rd", i),   s_rd, vt[i].e_rd);
            chk($sformatf("vec%0d_rr", i),   {31'd0, s_rr}, {31'd0, vt[i].e_rr});
            chk($sformatf("vec%0d_rw", i),   {31'd0, s_rw}, {31'd0, vt[i].e_rw});
            chk($sformatf("vec%0d_led", i),  {24'd0, bus.leds}, {24'd0, vt[i].e_led});
            chk($sformatf("vec%0d_digi", i), {20'd0, bus.digi}, {20'd0, vt[i].e_digi});
        end

        // Timer overflow with reload and interrupt.
        step(0, 0, 1, BASE + 32'h0, 32'hFFFF_FFF0, 0);
        step(0, 0, 1, BASE + 32'h4, 32'hFFFF_FFFE, 0);
        step(0, 0, 1, BASE + 32'h8, 32'h0000_0003, 0);
        step(0, 1, 0, BASE + 32'h4, 0, 0);
        chk("tl_held_while_disabled", s_rd, 32'hFFFF_FFFE);
        step(0, 1, 0, BASE + 32'h4, 0, 0);
        chk("tl_at_max", s_rd, 32'hFFFF_FFFF);
        chk("irq_after_reload", {31'd0, bus.irq}, 32'd1);
        step(0, 1, 0, BASE + 32'h4, 0, 0);
        chk("tl_reloaded", s_rd, 32'hFFFF_FFF0);

        // Write-0-to-clear on the status bit.
        step(0, 0, 1, BASE + 32'h8, 32'h0000_0007, 0);
        chk("irq_kept_by_write1", {31'd0, bus.irq}, 32'd1);
        step(0, 0, 1, BASE + 32'h8, 32'h0000_0003, 0);
        chk("irq_cleared", {31'd0, bus.irq}, 32'd0);
        step(0, 1, 0, BASE + 32'h8, 0, 0);
        chk("tcon_after_clear", s_rd, 32'd3);

        // CPU write to TL in the overflow cycle, then overflow against a clear.
        step(0, 0, 1, BASE + 32'h4, 32'hFFFF_FFFF, 0);
        step(0, 0, 1, BASE + 32'h4, 32'h0000_1234, 0);
        chk("no_irq_when_tl_written", {31'd0, bus.irq}, 32'd0);
        step(0, 1, 0, BASE + 32'h4, 0, 0);
        chk("tl_write_beats_reload", s_rd, 32'h0000_1234);
        step(0, 0, 1, BASE + 32'h4, 32'hFFFF_FFFF, 0);
        step(0, 0, 1, BASE + 32'h8, 32'h0000_0003, 0);
        chk("overflow_beats_clear_irq", {31'd0, bus.irq}, 32'd1);
        step(0, 1, 0, BASE + 32'h8, 0, 0);
        chk("overflow_beats_clear_tcon", s_rd, 32'd7);
        step(0, 1, 0, BASE + 32'h4, 0, 0);
        chk("tl_after_reload_count", s_rd, 32'hFFFF_FFF1);

        // Reset mid-count wins over a same-cycle store.
        step(1, 0, 1, BASE + 32'h4, 32'h0000_0005, 0);
        chk("rst_leds", {24'd0, bus.leds}, 32'd0);
        chk("rst_digi", {20'd0, bus.digi}, 32'd0);
        chk("rst_irq",  {31'd0, bus.irq},  32'd0);
        step(0, 1, 0, BASE + 32'h4, 0, 0);
        chk("rst_tl", s_rd, 32'd0);
        step(0, 1, 0, BASE + 32'h14, 0, 0);
        chk("rst_systick", s_rd, 32'd1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 800; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 3)      a = $urandom_range(0, 1023);
            else if (sel < 8) a = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            else              a = $urandom;
            wd = $urandom;
            if (pidx(a) == 1 && $urandom_range(0, 1) == 1) wd = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            if (pidx(a) == 2 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
            step($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 a, wd, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
